decode_mc: RTL and testbench

//  Parametrised multicycle control unit for the ARM-subset datapath: main FSM, ALU decoder, PC logic, instr decoder.

---
 rtl/decode_pkg.sv | 44 ++++
 rtl/decode_mc_if.sv | 39 +++
 rtl/decode_alu.sv | 53 +++++
 rtl/decode_mc.sv | 159 +++++++++++++++
 tb/tb_decode_mc.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_pkg.sv
// Shared encodings for the multicycle ARM-subset control unit: FSM states,
// ALU control codes, data-processing cmd codes and the MUL instruction pattern.
package decode_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_MULSTART = 4'd10,
    S_MULWAIT  = 4'd11,
    S_MULWB    = 4'd12
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_EOR = 3'd4;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [4:0] MUL_FUNCT = 5'b00000;
  localparam logic [3:0] MUL_74    = 4'b1001;

  // MUL shares Op=00 with data processing; only Instr[7:4]=1001 tells them apart.
  function automatic logic is_mul_pattern(input logic [1:0] op,
                                          input logic [5:0] funct,
                                          input logic [3:0] mul74);
    return (op == 2'b00) && (funct[5:1] == MUL_FUNCT) && (mul74 == MUL_74);
  endfunction

endpackage

// File: rtl/decode_mc_if.sv
// Instruction-field inputs, memory/multiplier handshakes and datapath control
// outputs of the multicycle control unit.
interface decode_mc_if #(parameter int ALU_W = 3);

  logic [1:0]       Op;
  logic [5:0]       Funct;
  logic [3:0]       Rd;
  logic [3:0]       Mul74;
  logic             MemReady;
  logic             MulDone;

  logic [1:0]       FlagW;
  logic             PCS;
  logic             NextPC;
  logic             RegW;
  logic             MemW;
  logic             IRWrite;
  logic             AdrSrc;
  logic             MulStart;
  logic [1:0]       ResultSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ImmSrc;
  logic [1:0]       RegSrc;
  logic [ALU_W-1:0] ALUControl;

  modport master (
    output Op, Funct, Rd, Mul74, MemReady, MulDone,
    input  FlagW, PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, MulStart,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl
  );

  modport slave (
    input  Op, Funct, Rd, Mul74, MemReady, MulDone,
    output FlagW, PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, MulStart,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl
  );

endinterface

// File: rtl/decode_alu.sv
// Combinational ALU decoder: maps cmd/S to ALU control, flag-write enables and
// a no-write indication consumed in the ALU writeback state.
module decode_alu
  import decode_pkg::*;
#(
  parameter bit EN_EOR = 1'b1
) (
  input  logic       alu_op,
  input  logic [3:0] cmd,
  input  logic       s_bit,
  output logic [2:0] alu_ctrl,
  output logic [1:0] flag_w,
  output logic       no_write
);

  logic supported;
  logic arith;
  logic is_cmp;

  always_comb begin
    supported = 1'b1;
    arith     = 1'b0;
    is_cmp    = 1'b0;
    alu_ctrl  = ALU_ADD;
    flag_w    = 2'b00;
    no_write  = 1'b0;
    case (cmd)
      CMD_ADD: begin alu_ctrl = ALU_ADD; arith = 1'b1; end
      CMD_SUB: begin alu_ctrl = ALU_SUB; arith = 1'b1; end
      // CMP without S has no architectural effect, so it is rejected outright.
      CMD_CMP: begin
        if (s_bit) begin
          alu_ctrl = ALU_SUB;
          arith    = 1'b1;
          is_cmp   = 1'b1;
        end else begin
          supported = 1'b0;
        end
      end
      CMD_AND: alu_ctrl = ALU_AND;
      CMD_ORR: alu_ctrl = ALU_ORR;
      CMD_EOR: begin
        if (EN_EOR) alu_ctrl = ALU_EOR;
        else        supported = 1'b0;
      end
      default: supported = 1'b0;
    endcase
    if (!supported || !alu_op) alu_ctrl = ALU_ADD;
    if (alu_op && supported)   flag_w = {s_bit, s_bit & arith};
    no_write = !supported || is_cmp;
  end

endmodule

// File: rtl/decode_mc.sv
// Multicycle control unit: main FSM with memory and multiplier handshakes,
// ALU decoder, PC-write logic and instruction-field decode.
module decode_mc
  import decode_pkg::*;
#(
  parameter int ALU_W  = 3,
  parameter bit EN_EOR = 1'b1,
  parameter bit EN_MUL = 1'b1
) (
  input logic        clk,
  input logic        reset,
  decode_mc_if.slave bus
);

  state_t     state;
  state_t     state_nxt;

  logic       irwrite_c;
  logic       nextpc_c;
  logic       regw_c;
  logic       memw_c;
  logic       mulstart_c;
  logic       adrsrc_c;
  logic       branch;
  logic       alu_op;
  logic       pcs_c;
  logic [1:0] resultsrc_c;
  logic [1:0] srca_c;
  logic [1:0] srcb_c;
  logic [2:0] alu_ctrl;
  logic [1:0] flag_w;
  logic       no_write;

  decode_alu #(.EN_EOR(EN_EOR)) u_alu (
    .alu_op   (alu_op),
    .cmd      (bus.Funct[4:1]),
    .s_bit    (bus.Funct[0]),
    .alu_ctrl (alu_ctrl),
    .flag_w   (flag_w),
    .no_write (no_write)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    irwrite_c   = 1'b0;
    nextpc_c    = 1'b0;
    regw_c      = 1'b0;
    memw_c      = 1'b0;
    mulstart_c  = 1'b0;
    adrsrc_c    = 1'b0;
    branch      = 1'b0;
    alu_op      = 1'b0;
    resultsrc_c = 2'b00;
    srca_c      = 2'b00;
    srcb_c      = 2'b00;
    case (state)
      S_FETCH: begin
        srca_c      = 2'b10;
        srcb_c      = 2'b10;
        resultsrc_c = 2'b10;
        irwrite_c   = bus.MemReady;
        nextpc_c    = bus.MemReady;
        if (bus.MemReady) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        srca_c      = 2'b10;
        srcb_c      = 2'b10;
        resultsrc_c = 2'b10;
        case (bus.Op)
          2'b01: state_nxt = S_MEMADR;
          2'b10: state_nxt = S_BRANCH;
          2'b00: begin
            if (EN_MUL && is_mul_pattern(bus.Op, bus.Funct, bus.Mul74)) state_nxt = S_MULSTART;
            else if (bus.Funct[5])                                      state_nxt = S_EXECI;
            else                                                        state_nxt = S_EXECR;
          end
          default: state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        srcb_c    = 2'b01;
        state_nxt = bus.Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        adrsrc_c = 1'b1;
        if (bus.MemReady) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc_c = 2'b01;
        regw_c      = 1'b1;
        state_nxt   = S_FETCH;
      end
      // The store stays on the bus until memory accepts it.
      S_MEMWR: begin
        adrsrc_c = 1'b1;
        memw_c   = 1'b1;
        if (bus.MemReady) state_nxt = S_FETCH;
      end
      S_EXECR: begin
        alu_op    = 1'b1;
        state_nxt = S_ALUWB;
      end
      S_EXECI: begin
        srcb_c    = 2'b01;
        alu_op    = 1'b1;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        regw_c    = !no_write;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        srca_c      = 2'b10;
        srcb_c      = 2'b01;
        resultsrc_c = 2'b10;
        branch      = 1'b1;
        state_nxt   = S_FETCH;
      end
      S_MULSTART: begin
        mulstart_c = 1'b1;
        state_nxt  = S_MULWAIT;
      end
      S_MULWAIT: begin
        if (bus.MulDone) state_nxt = S_MULWB;
      end
      S_MULWB: begin
        resultsrc_c = 2'b11;
        regw_c      = 1'b1;
        state_nxt   = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  assign pcs_c = (regw_c && (bus.Rd == 4'hF)) || branch;

  // Side-effecting strobes are held low for as long as reset is asserted.
  assign bus.IRWrite    = irwrite_c  & ~reset;
  assign bus.NextPC     = nextpc_c   & ~reset;
  assign bus.RegW       = regw_c     & ~reset;
  assign bus.MemW       = memw_c     & ~reset;
  assign bus.MulStart   = mulstart_c & ~reset;
  assign bus.PCS        = pcs_c      & ~reset;
  assign bus.FlagW      = reset ? 2'b00 : flag_w;

  assign bus.AdrSrc     = adrsrc_c;
  assign bus.ResultSrc  = resultsrc_c;
  assign bus.ALUSrcA    = srca_c;
  assign bus.ALUSrcB    = srcb_c;
  assign bus.ALUControl = ALU_W'(alu_ctrl);
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};

endmodule

// File: tb/tb_decode_mc.sv
// Self-checking bench for decode_mc: per-cycle expected control vectors are
// queued with their stimulus and compared as the FSM steps through each instruction.
module tb_decode_mc;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  decode_mc_if #(.ALU_W(3)) bus ();

  decode_mc #(.ALU_W(3), .EN_EOR(1'b1), .EN_MUL(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef enum {
    P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR, P_EXECR,
    P_EXECI, P_ALUWB, P_BRANCH, P_MULSTART, P_MULWAIT, P_MULWB
  } pst_e;

  typedef struct packed {
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] mul74;
    logic       mr;
    logic       md;
  } stim_t;

  typedef struct packed {
    logic       irwrite;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic       pcs;
    logic       mulstart;
    logic       adrsrc;
    logic [1:0] flagw;
    logic [1:0] resultsrc;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] immsrc;
    logic [1:0] regsrc;
    logic [2:0] aluctl;
  } obs_t;

  stim_t stq[$];
  obs_t  expq[$];
  pst_e  tagq[$];
  int    checks = 0;
  int    errors = 0;

  function automatic stim_t mk(input logic [1:0] op, input logic [5:0] funct,
                               input logic [3:0] rd, input logic [3:0] mul74);
    stim_t s;
    s.op = op; s.funct = funct; s.rd = rd; s.mul74 = mul74; s.mr = 1'b1; s.md = 1'b0;
    return s;
  endfunction

  // Reference ALU decode table: control code, flag enables, writeback suppressed.
  function automatic void alu_ref(input logic [5:0] f, output logic [2:0] ctl,
                                  output logic [1:0] fw, output logic nw);
    ctl = 3'd0; fw = 2'b00; nw = 1'b1;
    case (f[4:1])
      4'b0100: begin ctl = 3'd0; fw = {f[0], f[0]}; nw = 1'b0; end
      4'b0010: begin ctl = 3'd1; fw = {f[0], f[0]}; nw = 1'b0; end
      4'b1010: if (f[0]) begin ctl = 3'd1; fw = 2'b11; nw = 1'b1; end
      4'b0000: begin ctl = 3'd2; fw = {f[0], 1'b0}; nw = 1'b0; end
      4'b1100: begin ctl = 3'd3; fw = {f[0], 1'b0}; nw = 1'b0; end
      4'b0001: begin ctl = 3'd4; fw = {f[0], 1'b0}; nw = 1'b0; end
      default: ;
    endcase
  endfunction

  function automatic void plan(input pst_e st, input stim_t s);
    obs_t       e;
    logic [2:0] ctl;
    logic [1:0] fw;
    logic       nw;
    e        = '0;
    e.immsrc = s.op;
    e.regsrc = {s.op == 2'b01, s.op == 2'b10};
    alu_ref(s.funct, ctl, fw, nw);
    case (st)
      P_FETCH:    begin e.srca = 2'b10; e.srcb = 2'b10; e.resultsrc = 2'b10;
                        e.irwrite = s.mr; e.nextpc = s.mr; end
      P_DECODE:   begin e.srca = 2'b10; e.srcb = 2'b10; e.resultsrc = 2'b10; end
      P_MEMADR:   e.srcb = 2'b01;
      P_MEMRD:    e.adrsrc = 1'b1;
      P_MEMWB:    begin e.resultsrc = 2'b01; e.regw = 1'b1; end
      P_MEMWR:    begin e.adrsrc = 1'b1; e.memw = 1'b1; end
      P_EXECR:    begin e.aluctl = ctl; e.flagw = fw; end
      P_EXECI:    begin e.srcb = 2'b01; e.aluctl = ctl; e.flagw = fw; end
      P_ALUWB:    e.regw = !nw;
      P_BRANCH:   begin e.srca = 2'b10; e.srcb = 2'b01; e.resultsrc = 2'b10; e.pcs = 1'b1; end
      P_MULSTART: e.mulstart = 1'b1;
      P_MULWB:    begin e.resultsrc = 2'b11; e.regw = 1'b1; end
      default:    ;
    endcase
    if (e.regw && s.rd == 4'hF) e.pcs = 1'b1;
    stq.push_back(s);
    expq.push_back(e);
    tagq.push_back(st);
  endfunction

  task automatic drive(input stim_t s);
    bus.Op       = s.op;
    bus.Funct    = s.funct;
    bus.Rd       = s.rd;
    bus.Mul74    = s.mul74;
    bus.MemReady = s.mr;
    bus.MulDone  = s.md;
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.irwrite   = bus.IRWrite;
    o.nextpc    = bus.NextPC;
    o.regw      = bus.RegW;
    o.memw      = bus.MemW;
    o.pcs       = bus.PCS;
    o.mulstart  = bus.MulStart;
    o.adrsrc    = bus.AdrSrc;
    o.flagw     = bus.FlagW;
    o.resultsrc = bus.ResultSrc;
    o.srca      = bus.ALUSrcA;
    o.srcb      = bus.ALUSrcB;
    o.immsrc    = bus.ImmSrc;
    o.regsrc    = bus.RegSrc;
    o.aluctl    = bus.ALUControl;
    return o;
  endfunction

  task automatic test_reset();
    obs_t o;
    reset = 1'b1;
    drive(mk(2'b00, 6'b001000, 4'd1, 4'd0));
    repeat (3) @(negedge clk);
    #1;
    o = sample();
    checks++;
    if ({o.irwrite, o.nextpc} !== 2'b00) begin
      errors++; $display("FAIL reset_fetch_strobes: got %b required 00", {o.irwrite, o.nextpc});
    end
    checks++;
    if ({o.regw, o.memw, o.mulstart, o.pcs, o.flagw} !== 6'b0) begin
      errors++; $display("FAIL reset_write_strobes: got %b required 000000",
                         {o.regw, o.memw, o.mulstart, o.pcs, o.flagw});
    end
    checks++;
    if (o.srca !== 2'b10 || o.resultsrc !== 2'b10) begin
      errors++; $display("FAIL reset_state_fetch: got srca=%b resultsrc=%b required 10/10",
                         o.srca, o.resultsrc);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add();
    stim_t s; obs_t e; obs_t o; pst_e t;
    s = mk(2'b00, 6'b001000, 4'd1, 4'd0);
    plan(P_FETCH, s); plan(P_DECODE, s); plan(P_EXECR, s); plan(P_ALUWB, s);
    while (expq.size() > 0) begin
      s = stq.pop_front(); e = expq.pop_front(); t = tagq.pop_front();
      drive(s); #1; o = sample(); checks++;
      if (o !== e) begin errors++; $display("FAIL add_%s: got %h required %h", t.name(), o, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_subs_imm();
    stim_t s; obs_t e; obs_t o; pst_e t;
    s = mk(2'b00, 6'b100101, 4'd5, 4'd0);
    plan(P_FETCH, s); plan(P_DECODE, s); plan(P_EXECI, s); plan(P_ALUWB, s);
    while (expq.size() > 0) begin
      s = stq.pop_front(); e = expq.pop_front(); t = tagq.pop_front();
      drive(s); #1; o = sample(); checks++;
      if (o !== e) begin errors++; $display("FAIL subs_%s: got %h required %h", t.name(), o, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_cmp();
    stim_t s; obs_t e; obs_t o; pst_e t;
    s = mk(2'b00, 6'b010101, 4'd0, 4'd0);
    plan(P_FETCH, s); plan(P_DECODE, s); plan(P_EXECR, s); plan(P_ALUWB, s);
    while (expq.size() > 0) begin
      s = stq.pop_front(); e = expq.pop_front(); t = tagq.pop_front();
      drive(s); #1; o = sample(); checks++;
      if (o !== e) begin errors++; $display("FAIL cmp_%s: got %h required %h", t.name(), o, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_ldr_wait();
    stim_t s; stim_t w; obs_t e; obs_t o; pst_e t;
    s = mk(2'b01, 6'b000001, 4'd2, 4'd0);
    w = s; w.mr = 1'b0;
    plan(P_FETCH, s); plan(P_DECODE, w); plan(P_MEMADR, s);
    plan(P_MEMRD, w); plan(P_MEMRD, w); plan(P_MEMRD, w); plan(P_MEMRD, s);
    plan(P_MEMWB, s);
    while (expq.size() > 0) begin
      s = stq.pop_front(); e = expq.pop_front(); t = tagq.pop_front();
      drive(s); #1; o = sample(); checks++;
      if (o !== e) begin errors++; $display("FAIL ldr_%s: got %h required %h", t.name(), o, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_str_wait();
    stim_t s; stim_t w; obs_t e; obs_t o; pst_e t;
    s = mk(2'b01, 6'b000000, 4'd3, 4'd0);
    w = s; w.mr = 1'b0;
    plan(P_FETCH, s); plan(P_DECODE, s); plan(P_MEMADR, s);
    plan(P_MEMWR, w); plan(P_MEMWR, w); plan(P_MEMWR, s);
    while (expq.size() > 0) begin
      s = stq.pop_front(); e = expq.pop_front(); t = tagq.pop_front();
      drive(s); #1; o = sample(); checks++;
      if (o !== e) begin errors++; $display("FAIL str_%s: got %h required %h", t.name(), o, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_mul();
    stim_t s; stim_t d; stim_t n; obs_t e; obs_t o; pst_e t;
    s = mk(2'b00, 6'b000000, 4'd6, 4'b1001);
    n = s; n.mr = 1'b0;
    d = s; d.md = 1'b1;
    plan(P_FETCH, s); plan(P_DECODE, n); plan(P_MULSTART, d);
    for (int i = 0; i < 4; i++) plan(P_MULWAIT, s);
    plan(P_MULWAIT, d); plan(P_MULWB, s);
    while (expq.size() > 0) begin
      s = stq.pop_front(); e = expq.pop_front(); t = tagq.pop_front();
      drive(s); #1; o = sample(); checks++;
      if (o !== e) begin errors++; $display("FAIL mul_%s: got %h required %h", t.name(), o, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    stim_t s; stim_t w; obs_t e; obs_t o; pst_e t;
    s = mk(2'b10, 6'b101010, 4'd7, 4'd0);
    w = s; w.mr = 1'b0;
    plan(P_FETCH, w); plan(P_FETCH, s); plan(P_DECODE, s); plan(P_BRANCH, s);
    while (expq.size() > 0) begin
      s = stq.pop_front(); e = expq.pop_front(); t = tagq.pop_front();
      drive(s); #1; o = sample(); checks++;
      if (o !== e) begin errors++; $display("FAIL branch_%s: got %h required %h", t.name(), o, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_pc_write();
    stim_t s; obs_t e; obs_t o; pst_e t;
    s = mk(2'b00, 6'b001000, 4'hF, 4'd0);
    plan(P_FETCH, s); plan(P_DECODE, s); plan(P_EXECR, s); plan(P_ALUWB, s);
    while (expq.size() > 0) begin
      s = stq.pop_front(); e = expq.pop_front(); t = tagq.pop_front();
      drive(s); #1; o = sample(); checks++;
      if (o !== e) begin errors++; $display("FAIL pcwrite_%s: got %h required %h", t.name(), o, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_eor_unsupported();
    stim_t s; stim_t u; stim_t x; obs_t e; obs_t o; pst_e t;
    s = mk(2'b00, 6'b000011, 4'd8, 4'd0);
    u = mk(2'b00, 6'b011110, 4'hF, 4'd0);
    x = mk(2'b11, 6'b000000, 4'd9, 4'd0);
    plan(P_FETCH, s); plan(P_DECODE, s); plan(P_EXECR, s); plan(P_ALUWB, s);
    plan(P_FETCH, u); plan(P_DECODE, u); plan(P_EXECR, u); plan(P_ALUWB, u);
    plan(P_FETCH, x); plan(P_DECODE, x);
    while (expq.size() > 0) begin
      s = stq.pop_front(); e = expq.pop_front(); t = tagq.pop_front();
      drive(s); #1; o = sample(); checks++;
      if (o !== e) begin errors++; $display("FAIL eor_unsup_%s: got %h required %h", t.name(), o, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midop();
    stim_t s; stim_t w; obs_t e; obs_t o; pst_e t;
    s = mk(2'b01, 6'b000000, 4'd4, 4'd0);
    w = s; w.mr = 1'b0;
    plan(P_FETCH, s); plan(P_DECODE, s); plan(P_MEMADR, s); plan(P_MEMWR, w);
    while (expq.size() > 0) begin
      s = stq.pop_front(); e = expq.pop_front(); t = tagq.pop_front();
      drive(s); #1; o = sample(); checks++;
      if (o !== e) begin errors++; $display("FAIL rstmid_%s: got %h required %h", t.name(), o, e); end
      @(negedge clk);
    end
    reset = 1'b1;
    drive(w);
    #1; o = sample(); checks++;
    if (o.memw !== 1'b0) begin errors++; $display("FAIL rstmid_memw_forced: got %b required 0", o.memw); end
    @(negedge clk);
    drive(s);
    #1; o = sample(); checks++;
    if ({o.irwrite, o.nextpc, o.memw, o.srca} !== 5'b00010) begin
      errors++; $display("FAIL rstmid_fetch_held: got %b required 00010",
                         {o.irwrite, o.nextpc, o.memw, o.srca});
    end
    @(negedge clk);
    reset = 1'b0;
    drive(w);
    #1; o = sample(); checks++;
    if ({o.memw, o.regw, o.mulstart, o.adrsrc, o.srca, o.srcb} !== 8'b0000_1010) begin
      errors++; $display("FAIL rstmid_after_release: got %b required 00001010",
                         {o.memw, o.regw, o.mulstart, o.adrsrc, o.srca, o.srcb});
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    stim_t a; stim_t b; stim_t w; stim_t s; obs_t e; obs_t o; pst_e t;
    a = mk(2'b00, 6'b011001, 4'd4, 4'd0);
    b = mk(2'b01, 6'b000001, 4'hF, 4'd0);
    w = b; w.mr = 1'b0;
    plan(P_FETCH, a); plan(P_DECODE, a); plan(P_EXECR, a); plan(P_ALUWB, a);
    plan(P_FETCH, b); plan(P_DECODE, b); plan(P_MEMADR, b); plan(P_MEMRD, b); plan(P_MEMWB, b);
    plan(P_FETCH, w);
    while (expq.size() > 0) begin
      s = stq.pop_front(); e = expq.pop_front(); t = tagq.pop_front();
      drive(s); #1; o = sample(); checks++;
      if (o !== e) begin errors++; $display("FAIL b2b_%s: got %h required %h", t.name(), o, e); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_subs_imm();
    test_cmp();
    test_ldr_wait();
    test_str_wait();
    test_mul();
    test_branch();
    test_pc_write();
    test_eor_unsupported();
    test_reset_midop();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
